// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: owns the TLB search/read/write/invalidate ports for
// TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB retiring in WB, one op in flight at a time.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op_type,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [18:0]      inv_va,
    output logic             op_ready,
    output logic             op_done,
    output logic             op_err,
    output logic             refetch_flush,
    input  logic [31:0]      csr_tlbidx,
    input  logic [31:0]      csr_tlbehi,
    input  logic [31:0]      csr_tlbelo0,
    input  logic [31:0]      csr_tlbelo1,
    input  logic [9:0]       csr_asid,
    output logic [18:0]      tlb_s_vppn,
    output logic [9:0]       tlb_s_asid,
    input  logic             tlb_s_found,
    input  logic [IDX_W-1:0] tlb_s_index,
    output logic [IDX_W-1:0] tlb_r_index,
    input  logic [95:0]      tlb_r_data,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_w_index,
    output logic             tlb_w_ne,
    output logic             inv_valid,
    output logic [4:0]       inv_op_o,
    output logic [9:0]       inv_asid_o,
    output logic [18:0]      inv_va_o,
    output logic [4:0]       csr_tlb_we,
    output logic [31:0]      tlbidx_wdata,
    output logic [31:0]      tlbehi_wdata,
    output logic [31:0]      tlbelo0_wdata,
    output logic [31:0]      tlbelo1_wdata,
    output logic [9:0]       asid_wdata
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SRCH_REQ  = 4'd1;
    localparam logic [3:0] S_SRCH_RESP = 4'd2;
    localparam logic [3:0] S_RD_REQ    = 4'd3;
    localparam logic [3:0] S_RD_RESP   = 4'd4;
    localparam logic [3:0] S_WR        = 4'd5;
    localparam logic [3:0] S_INV       = 4'd6;
    localparam logic [3:0] S_ERR       = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    // tlb_r_data layout: {e[95], ps[94:89], vppn[88:70], asid[69:60], elo0[59:30], elo1[29:0]}
    logic        r_e;
    logic [5:0]  r_ps;
    logic [18:0] r_vppn;
    logic [9:0]  r_asid;
    logic [29:0] r_elo0, r_elo1;
    assign {r_e, r_ps, r_vppn, r_asid, r_elo0, r_elo1} = tlb_r_data;

    // ELO CSRs reach the TLB write data path outside this block.
    logic unused_elo;
    assign unused_elo = ^{csr_tlbelo0, csr_tlbelo1};

    logic [3:0]       state_q, state_d;
    logic [2:0]       type_q, type_d;
    logic [31:0]      idx_q, idx_d;
    logic [18:0]      vppn_q, vppn_d;
    logic [9:0]       asid_q, asid_d;
    logic [4:0]       iop_q, iop_d;
    logic [9:0]       iasid_q, iasid_d;
    logic [18:0]      iva_q, iva_d;
    logic [IDX_W-1:0] fill_ctr_q, fill_ctr_d;
    logic [4:0]       cwe_q, cwe_d;
    logic [31:0]      idx_wd_q, idx_wd_d;
    logic [31:0]      ehi_wd_q, ehi_wd_d;
    logic [31:0]      elo0_wd_q, elo0_wd_d;
    logic [31:0]      elo1_wd_q, elo1_wd_d;
    logic [9:0]       asid_wd_q, asid_wd_d;

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        idx_d      = idx_q;
        vppn_d     = vppn_q;
        asid_d     = asid_q;
        iop_d      = iop_q;
        iasid_d    = iasid_q;
        iva_d      = iva_q;
        fill_ctr_d = fill_ctr_q + IDX_W'(1);
        cwe_d      = 5'b00000;
        idx_wd_d   = idx_wd_q;
        ehi_wd_d   = ehi_wd_q;
        elo0_wd_d  = elo0_wd_q;
        elo1_wd_d  = elo1_wd_q;
        asid_wd_d  = asid_wd_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    type_d  = op_type;
                    idx_d   = csr_tlbidx;
                    vppn_d  = csr_tlbehi[31:13];
                    asid_d  = csr_asid;
                    iop_d   = inv_op;
                    iasid_d = inv_asid;
                    iva_d   = inv_va;
                    case (op_type)
                        3'd0:       state_d = S_SRCH_REQ;
                        3'd1:       state_d = S_RD_REQ;
                        3'd2, 3'd3: state_d = S_WR;
                        3'd4:       state_d = (inv_op > 5'd6) ? S_ERR : S_INV;
                        default:    state_d = S_ERR;
                    endcase
                end
            end
            S_SRCH_REQ: state_d = S_SRCH_RESP;
            S_SRCH_RESP: begin
                cwe_d    = 5'b00001;
                idx_wd_d = tlb_s_found ? {1'b0, idx_q[30:IDX_W], tlb_s_index}
                                       : {1'b1, idx_q[30:0]};
                state_d  = S_DONE;
            end
            S_RD_REQ: state_d = S_RD_RESP;
            S_RD_RESP: begin
                cwe_d = 5'b11111;
                if (r_e) begin
                    idx_wd_d  = {1'b0, idx_q[30], r_ps, idx_q[23:0]};
                    ehi_wd_d  = {r_vppn, 13'b0};
                    elo0_wd_d = {2'b00, r_elo0};
                    elo1_wd_d = {2'b00, r_elo1};
                    asid_wd_d = r_asid;
                end else begin
                    idx_wd_d  = {1'b1, idx_q[30], 6'b0, idx_q[23:0]};
                    ehi_wd_d  = '0;
                    elo0_wd_d = '0;
                    elo1_wd_d = '0;
                    asid_wd_d = '0;
                end
                state_d = S_DONE;
            end
            S_WR, S_INV: state_d = S_DONE;
            // ERR reports completion itself so an illegal op retires one cycle after accept.
            S_ERR:   state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            type_q     <= '0;
            idx_q      <= '0;
            vppn_q     <= '0;
            asid_q     <= '0;
            iop_q      <= '0;
            iasid_q    <= '0;
            iva_q      <= '0;
            fill_ctr_q <= '0;
            cwe_q      <= '0;
            idx_wd_q   <= '0;
            ehi_wd_q   <= '0;
            elo0_wd_q  <= '0;
            elo1_wd_q  <= '0;
            asid_wd_q  <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            idx_q      <= idx_d;
            vppn_q     <= vppn_d;
            asid_q     <= asid_d;
            iop_q      <= iop_d;
            iasid_q    <= iasid_d;
            iva_q      <= iva_d;
            fill_ctr_q <= fill_ctr_d;
            cwe_q      <= cwe_d;
            idx_wd_q   <= idx_wd_d;
            ehi_wd_q   <= ehi_wd_d;
            elo0_wd_q  <= elo0_wd_d;
            elo1_wd_q  <= elo1_wd_d;
            asid_wd_q  <= asid_wd_d;
        end
    end

    assign op_ready      = (state_q == S_IDLE);
    assign op_done       = (state_q == S_DONE) || (state_q == S_ERR);
    assign op_err        = (state_q == S_ERR);
    assign refetch_flush = (state_q == S_DONE) &&
                           ((type_q == 3'd2) || (type_q == 3'd3) || (type_q == 3'd4));

    assign tlb_s_vppn  = vppn_q;
    assign tlb_s_asid  = asid_q;
    assign tlb_r_index = idx_q[IDX_W-1:0];

    assign tlb_we      = (state_q == S_WR);
    assign tlb_w_index = (type_q == 3'd3) ? fill_ctr_q : idx_q[IDX_W-1:0];
    assign tlb_w_ne    = idx_q[31];

    assign inv_valid  = (state_q == S_INV);
    assign inv_op_o   = iop_q;
    assign inv_asid_o = iasid_q;
    assign inv_va_o   = iva_q;

    // CSR write-back is registered so it lands together with op_done.
    assign csr_tlb_we    = cwe_q;
    assign tlbidx_wdata  = idx_wd_q;
    assign tlbehi_wdata  = ehi_wd_q;
    assign tlbelo0_wdata = elo0_wd_q;
    assign tlbelo1_wdata = elo1_wd_q;
    assign asid_wdata    = asid_wd_q;

endmodule
